// File: rtl/call_dispatcher.sv
// Single-car floor-call dispatcher: latches floor calls, picks the next target
// on a sweep (elevator) policy and hands it to the car controller with a valid level.
module call_dispatcher #(
   parameter int NFLOOR = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              enable,
   input  logic [NFLOOR-1:0] call_req,
   input  logic [2:0]        car_location,
   input  logic              car_shut,
   output logic [2:0]        dest,
   output logic              open,
   output logic [NFLOOR-1:0] pending,
   output logic              up,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_SERVE = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        dest_q, dest_d;
   logic              open_q, open_d;
   logic [NFLOOR-1:0] pending_q, pending_d;
   logic              up_q, up_d;

   logic [2:0]        lo_ge_s, hi_le_s, target_s;
   logic              has_ge_s, has_le_s, target_up_s;
   logic [NFLOOR-1:0] dest_mask_s, absorb_mask_s;
   logic              dispatch_s, shut_s;

   // Scan pending calls: lowest floor at/above the car, highest at/below it.
   always_comb begin
      lo_ge_s  = 3'd0;
      hi_le_s  = 3'd0;
      has_ge_s = 1'b0;
      has_le_s = 1'b0;
      for (int i = NFLOOR - 1; i >= 0; i--) begin
         lo_ge_s  = (pending_q[i] && (3'(i) >= car_location)) ? 3'(i) : lo_ge_s;
         has_ge_s = has_ge_s | (pending_q[i] && (3'(i) >= car_location));
      end
      for (int i = 0; i < NFLOOR; i++) begin
         hi_le_s  = (pending_q[i] && (3'(i) <= car_location)) ? 3'(i) : hi_le_s;
         has_le_s = has_le_s | (pending_q[i] && (3'(i) <= car_location));
      end
   end

   // Sweep policy: keep going the current way, reverse only when nothing lies ahead.
   always_comb begin
      target_s    = dest_q;
      target_up_s = up_q;
      if (up_q) begin
         if (has_ge_s) begin
            target_s    = lo_ge_s;
            target_up_s = 1'b1;
         end else begin
            target_s    = hi_le_s;
            target_up_s = 1'b0;
         end
      end else begin
         if (has_le_s) begin
            target_s    = hi_le_s;
            target_up_s = 1'b0;
         end else begin
            target_s    = lo_ge_s;
            target_up_s = 1'b1;
         end
      end
   end

   // One-hot decode of the current destination.
   always_comb begin
      dest_mask_s = {NFLOOR{1'b0}};
      for (int i = 0; i < NFLOOR; i++) begin
         dest_mask_s[i] = (dest_q == 3'(i));
      end
   end

   assign dispatch_s    = (state_q == S_IDLE) && enable && (|pending_q);
   assign shut_s        = (state_q == S_SERVE) && enable && car_shut;
   // Calls for the floor being served are absorbed, not re-latched.
   assign absorb_mask_s = (state_q == S_SERVE) ? dest_mask_s : {NFLOOR{1'b0}};

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (dispatch_s) state_d = S_RUN;
            else            state_d = S_IDLE;
         end
         S_RUN: begin
            if (enable && (car_location == dest_q)) state_d = S_SERVE;
            else                                    state_d = S_RUN;
         end
         S_SERVE: begin
            if (shut_s) state_d = S_GAP;
            else        state_d = S_SERVE;
         end
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output/datapath next values.
   always_comb begin
      dest_d    = dest_q;
      open_d    = open_q;
      up_d      = up_q;
      pending_d = pending_q | (call_req & ~absorb_mask_s);
      case (state_q)
         S_IDLE: begin
            if (dispatch_s) begin
               dest_d = target_s;
               open_d = 1'b1;
               up_d   = target_up_s;
            end else begin
               open_d = 1'b0;
            end
         end
         S_RUN: open_d = 1'b1;
         S_SERVE: begin
            if (shut_s) begin
               pending_d = pending_d & ~dest_mask_s;
               open_d    = 1'b0;
            end else begin
               open_d    = 1'b1;
            end
         end
         S_GAP:   open_d = 1'b0;
         default: open_d = 1'b0;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         dest_q    <= 3'd0;
         open_q    <= 1'b0;
         pending_q <= {NFLOOR{1'b0}};
         up_q      <= 1'b1;
      end else begin
         dest_q    <= dest_d;
         open_q    <= open_d;
         pending_q <= pending_d;
         up_q      <= up_d;
      end
   end

   assign dest    = dest_q;
   assign open    = open_q;
   assign pending = pending_q;
   assign up      = up_q;
   assign state   = state_q;

endmodule

// File: tb/tb_call_dispatcher.sv
// Directed bench for call_dispatcher with hand-computed expectations.
module tb_call_dispatcher;

   logic       clk = 1'b0;
   logic       resetn;
   logic       enable;
   logic [7:0] call_req;
   logic [2:0] car_location;
   logic       car_shut;
   logic [2:0] dest;
   logic       open;
   logic [7:0] pending;
   logic       up;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, SERVE = 2'd2, GAP = 2'd3;

   call_dispatcher #(.NFLOOR(8)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .enable       (enable),
      .call_req     (call_req),
      .car_location (car_location),
      .car_shut     (car_shut),
      .dest         (dest),
      .open         (open),
      .pending      (pending),
      .up           (up),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [1:0] st, input logic [2:0] d,
                          input logic o, input logic [7:0] p, input logic u);
      chk_eq({tag, ".state"},   32'(state),   32'(st));
      chk_eq({tag, ".dest"},    32'(dest),    32'(d));
      chk_eq({tag, ".open"},    32'(open),    32'(o));
      chk_eq({tag, ".pending"}, 32'(pending), 32'(p));
      chk_eq({tag, ".up"},      32'(up),      32'(u));
   endtask

   initial begin
      resetn       = 1'b0;
      enable       = 1'b1;
      call_req     = 8'h00;
      car_location = 3'd0;
      car_shut     = 1'b0;
      tick();
      tick();
      chk_all("reset", IDLE, 3'd0, 1'b0, 8'h00, 1'b1);
      resetn = 1'b1;
      tick();

      // Basic dispatch to floor 4 from floor 0.
      call_req = 8'h10;
      tick();
      chk_all("latch4", IDLE, 3'd0, 1'b0, 8'h10, 1'b1);
      call_req = 8'h00;
      tick();
      chk_all("disp4", RUN, 3'd4, 1'b1, 8'h10, 1'b1);
      car_location = 3'd4;
      tick();
      chk_all("serve4", SERVE, 3'd4, 1'b1, 8'h10, 1'b1);
      car_shut = 1'b1;
      tick();
      chk_all("shut4", GAP, 3'd4, 1'b0, 8'h00, 1'b1);
      car_shut = 1'b0;
      tick();
      chk_all("gap_idle", IDLE, 3'd4, 1'b0, 8'h00, 1'b1);
      tick();
      chk_eq("open_low2", 32'(open), 32'd0);

      // Floors {1,6} from floor 3 going up: take 6.
      car_location = 3'd3;
      call_req     = 8'h42;
      tick();
      chk_eq("latch16", 32'(pending), 32'h42);
      call_req = 8'h00;
      tick();
      chk_all("disp6", RUN, 3'd6, 1'b1, 8'h42, 1'b1);

      // Closer call and stray car_shut while running: dest holds.
      call_req = 8'h10;
      car_shut = 1'b1;
      tick();
      chk_all("run_newcall", RUN, 3'd6, 1'b1, 8'h52, 1'b1);
      call_req     = 8'h00;
      car_shut     = 1'b0;
      car_location = 3'd6;
      tick();
      chk_all("serve6", SERVE, 3'd6, 1'b1, 8'h52, 1'b1);

      // Frozen in SERVE: car_shut ignored, call still latched.
      enable   = 1'b0;
      car_shut = 1'b1;
      call_req = 8'h04;
      tick();
      chk_all("frozen", SERVE, 3'd6, 1'b1, 8'h56, 1'b1);
      // Re-enable: shut clears floor 6 even with a simultaneous call for 6.
      enable   = 1'b1;
      call_req = 8'h40;
      tick();
      chk_all("absorb6", GAP, 3'd6, 1'b0, 8'h16, 1'b1);
      call_req = 8'h00;
      car_shut = 1'b0;
      tick();
      chk_eq("gap2idle", 32'(state), 32'(IDLE));

      // At 6 going up, nothing above: reverse, highest below = 4.
      tick();
      chk_all("rev4", RUN, 3'd4, 1'b1, 8'h16, 1'b0);
      car_location = 3'd4;
      tick();
      chk_eq("serve4b", 32'(state), 32'(SERVE));
      car_shut = 1'b1;
      tick();
      chk_all("shut4b", GAP, 3'd4, 1'b0, 8'h06, 1'b0);
      car_shut = 1'b0;
      tick();
      chk_eq("open_gap_b", 32'(open), 32'd0);
      tick();
      chk_all("down2", RUN, 3'd2, 1'b1, 8'h06, 1'b0);

      // Async reset mid-RUN with pending = 8'h26.
      call_req = 8'h20;
      tick();
      chk_eq("pend26", 32'(pending), 32'h26);
      call_req = 8'h00;
      #2;
      resetn = 1'b0;
      #1;
      chk_all("async_rst", IDLE, 3'd0, 1'b0, 8'h00, 1'b1);
      tick();
      resetn = 1'b1;
      tick();
      tick();
      chk_all("post_rst", IDLE, 3'd0, 1'b0, 8'h00, 1'b1);

      // Call for the car's own floor.
      car_location = 3'd5;
      call_req     = 8'h20;
      tick();
      call_req = 8'h00;
      tick();
      chk_all("self5", RUN, 3'd5, 1'b1, 8'h20, 1'b1);
      tick();
      chk_eq("self5_serve", 32'(state), 32'(SERVE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
